score_read_sequencer: RTL and testbench

- Upstream feeder of the score-RAM output manager: walks the (N+1)x(M+1) NW score matrix row-major over the interior cells (1,1)..(N,M).
- For each cell, issues three score-RAM reads in the order diag, left, up.
- Generates the en_read/count strobes aligned to RAM read data, so the output manager can assemble diag/left/up.
- Stalls until the score/write-back stage acknowledges the cell, then advances.

---
 rtl/score_read_sequencer.sv | 101 ++++++++++
 tb/tb_score_read_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/score_read_sequencer.sv
// score_read_sequencer: walks the NW score matrix row-major, issuing diag/left/up
// RAM reads per cell and aligning en_read/count to the returning read data.
module score_read_sequencer #(
    parameter int N      = 8,
    parameter int M      = 8,
    parameter int ADDR_W = 7,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cell_done,
    output logic                     ram_re,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     en_read,
    output logic [1:0]               count,
    output logic [$clog2(N+1)-1:0]   row_i,
    output logic [$clog2(M+1)-1:0]   col_j,
    output logic                     busy,
    output logic                     done
);
    localparam int RW = $clog2(N+1);
    localparam int CW = $clog2(M+1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(M+1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    state_t             state, state_n;
    logic [1:0]         k, k_n;
    logic [RW-1:0]      i_n;
    logic [CW-1:0]      j_n;
    logic [ADDR_W-1:0]  base, base_n, addr_n;
    logic [RD_LAT-1:0]  vld;
    logic [1:0]         cnt [RD_LAT];
    logic               accept, last, wrap;

    assign ram_re  = state == ISSUE;
    assign busy    = state != IDLE;
    assign done    = state == FIN;
    assign en_read = vld[RD_LAT-1];
    assign count   = cnt[RD_LAT-1];

    always_comb begin
        accept = state == WAIT && cell_done && vld == '0;
        last   = row_i == RW'(N) && col_j == CW'(M);
        wrap   = col_j == CW'(M);
        state_n = state;
        k_n     = k;
        i_n     = row_i;
        j_n     = col_j;
        base_n  = base;
        case (state)
            IDLE:  state_n = start ? ISSUE : IDLE;
            ISSUE: begin
                k_n     = k == 2'd2 ? 2'd0 : k + 2'd1;
                state_n = k == 2'd2 ? WAIT : ISSUE;
            end
            WAIT: if (accept) begin
                state_n = last ? FIN : ISSUE;
                j_n     = last ? col_j : wrap ? CW'(1) : col_j + CW'(1);
                i_n     = !last && wrap ? row_i + RW'(1) : row_i;
                base_n  = !last && wrap ? base + STRIDE : base;
            end
            FIN: begin
                state_n = IDLE;
                i_n     = RW'(1);
                j_n     = CW'(1);
                base_n  = STRIDE;
            end
            default: state_n = IDLE;
        endcase
        // base holds i*(M+1); diag/left/up are fixed offsets from base+j
        addr_n = base_n + ADDR_W'(j_n) - (k_n == 2'd0 ? STRIDE + ADDR_W'(1) : k_n == 2'd1 ? ADDR_W'(1) : STRIDE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= 2'd0;
            row_i    <= RW'(1);
            col_j    <= CW'(1);
            base     <= STRIDE;
            ram_addr <= '0;
            vld      <= '0;
            for (int s = 0; s < RD_LAT; s++) cnt[s] <= 2'd0;
        end else begin
            state  <= state_n;
            k      <= k_n;
            row_i  <= i_n;
            col_j  <= j_n;
            base   <= base_n;
            if (state_n == ISSUE) ram_addr <= addr_n;
            vld[0] <= ram_re;
            cnt[0] <= ram_re ? k : 2'd0;
            for (int s = 1; s < RD_LAT; s++) begin
                vld[s] <= vld[s-1];
                cnt[s] <= cnt[s-1];
            end
        end
    end
endmodule

// File: tb/tb_score_read_sequencer.sv
// tb_score_read_sequencer: directed + randomized checks of the score read sequencer
// across four parameter sets, against an address/ordering model of the matrix walk.
module tb_score_read_sequencer;
    logic clk = 0;
    logic rst, c_rst;
    logic a_st, a_cd, b_st, b_cd, c_st, c_cd, d_st, d_cd;
    logic a_re, a_en, a_busy, a_done, b_re, b_en, b_busy, b_done;
    logic c_re, c_en, c_busy, c_done, d_re, d_en, d_busy, d_done;
    logic [6:0] a_addr, b_addr, c_addr, d_addr;
    logic [1:0] a_cnt, b_cnt, c_cnt, d_cnt;
    logic [3:0] a_ri, a_cj, b_ri, b_cj, c_ri, c_cj;
    logic [0:0] d_ri, d_cj;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_re_t[$], a_en_t[$], a_done_n = 0;
    logic [6:0] a_addr_q[$];
    logic [1:0] a_cnt_q[$], b_cnt_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    score_read_sequencer #(.N(8), .M(8), .ADDR_W(7), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_st), .cell_done(a_cd), .ram_re(a_re), .ram_addr(a_addr),
        .en_read(a_en), .count(a_cnt), .row_i(a_ri), .col_j(a_cj), .busy(a_busy), .done(a_done));
    score_read_sequencer #(.N(8), .M(8), .ADDR_W(7), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(b_st), .cell_done(b_cd), .ram_re(b_re), .ram_addr(b_addr),
        .en_read(b_en), .count(b_cnt), .row_i(b_ri), .col_j(b_cj), .busy(b_busy), .done(b_done));
    score_read_sequencer #(.N(8), .M(8), .ADDR_W(7), .RD_LAT(2)) dut_c (
        .clk(clk), .rst(c_rst), .start(c_st), .cell_done(c_cd), .ram_re(c_re), .ram_addr(c_addr),
        .en_read(c_en), .count(c_cnt), .row_i(c_ri), .col_j(c_cj), .busy(c_busy), .done(c_done));
    score_read_sequencer #(.N(1), .M(1), .ADDR_W(7), .RD_LAT(1)) dut_d (
        .clk(clk), .rst(rst), .start(d_st), .cell_done(d_cd), .ram_re(d_re), .ram_addr(d_addr),
        .en_read(d_en), .count(d_cnt), .row_i(d_ri), .col_j(d_cj), .busy(d_busy), .done(d_done));

    always @(negedge clk) begin
        if (a_re) begin a_re_t.push_back(cyc); a_addr_q.push_back(a_addr); end
        if (a_en) begin a_en_t.push_back(cyc); a_cnt_q.push_back(a_cnt); end
        if (a_done) a_done_n++;
        if (b_en) b_cnt_q.push_back(b_cnt);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int cell_addr(input int r, input int c, input int m);
        return r * (m + 1) + c;
    endfunction

    initial begin
        int n, nidx;
        rst = 1; c_rst = 1;
        {a_st, a_cd, b_st, b_cd, c_st, c_cd, d_st, d_cd} = '0;
        tick; tick;
        chk("rst_re", a_re, 0);     chk("rst_addr", a_addr, 0); chk("rst_en", a_en, 0);
        chk("rst_cnt", a_cnt, 0);   chk("rst_busy", a_busy, 0); chk("rst_done", a_done, 0);
        chk("rst_row", a_ri, 1);    chk("rst_col", a_cj, 1);    chk("rst_d_busy", d_busy, 0);
        rst = 0; c_rst = 0;
        tick;

        // A: first cell, start beats cell_done in IDLE, start while busy ignored
        a_st = 1; a_cd = 1; tick; a_cd = 0;
        chk("a_t1_re", a_re, 1); chk("a_t1_addr", a_addr, 0); chk("a_t1_busy", a_busy, 1); chk("a_t1_en", a_en, 0);
        tick; a_st = 0;
        chk("a_t2_addr", a_addr, 9); chk("a_t2_en", a_en, 1); chk("a_t2_cnt", a_cnt, 0);
        tick;
        chk("a_t3_addr", a_addr, 1); chk("a_t3_en", a_en, 1); chk("a_t3_cnt", a_cnt, 1);
        tick;
        chk("a_t4_re", a_re, 0); chk("a_t4_en", a_en, 1); chk("a_t4_cnt", a_cnt, 2); chk("a_t4_addr", a_addr, 1);
        a_cd = 1; tick; a_cd = 0;
        chk("a_early_re", a_re, 0); chk("a_early_col", a_cj, 1);
        a_cd = 1; tick; a_cd = 0;
        chk("a_c2_re", a_re, 1); chk("a_c2_addr", a_addr, 1); chk("a_c2_row", a_ri, 1); chk("a_c2_col", a_cj, 2);

        // A: rest of the pass with random acknowledge delays and ignored noise
        for (int idx = 1; idx < 64; idx++) begin
            n = 0;
            while ((a_re || a_en) && n < 20) begin
                a_cd = a_re && ($urandom_range(0, 3) == 0);
                tick; n++;
            end
            a_cd = 0;
            chk("a_wait_bound", n < 20, 1);
            repeat ($urandom_range(0, 2)) begin a_st = 1'($urandom_range(0, 1)); tick; end
            a_st = 0; a_cd = 1; tick; a_cd = 0;
            nidx = idx + 1;
            if (idx < 63) begin
                chk("a_adv_re", a_re, 1);
                chk("a_adv_row", a_ri, 1 + nidx / 8);
                chk("a_adv_col", a_cj, 1 + nidx % 8);
            end else begin
                chk("a_fin_done", a_done, 1); chk("a_fin_re", a_re, 0); chk("a_fin_busy", a_busy, 1);
            end
        end
        tick;
        chk("a_idle_done", a_done, 0); chk("a_idle_busy", a_busy, 0);
        chk("a_idle_row", a_ri, 1);    chk("a_idle_col", a_cj, 1);
        chk("a_done_n", a_done_n, 1);
        chk("a_n_reads", a_addr_q.size(), 192);
        chk("a_n_en", a_en_t.size(), 192);
        if (a_addr_q.size() == 192 && a_en_t.size() == 192) begin
            for (int q = 0; q < 64; q++) begin
                int r, c;
                r = 1 + q / 8; c = 1 + q % 8;
                chk("a_diag", a_addr_q[3*q],   cell_addr(r - 1, c - 1, 8));
                chk("a_left", a_addr_q[3*q+1], cell_addr(r, c - 1, 8));
                chk("a_up",   a_addr_q[3*q+2], cell_addr(r - 1, c, 8));
            end
            for (int q = 0; q < 192; q++) begin
                chk("a_en_lat", a_en_t[q] - a_re_t[q], 1);
                chk("a_en_cnt", a_cnt_q[q], q % 3);
            end
            chk("a_last_diag", a_addr_q[189], 70);
            chk("a_last_left", a_addr_q[190], 79);
            chk("a_last_up",   a_addr_q[191], 71);
        end

        // B: RD_LAT=3, cell_done during ISSUE and with reads still in flight
        b_st = 1; tick; b_st = 0;
        b_cd = 1; tick; b_cd = 0;
        chk("b_issue_ign", b_re, 1); chk("b_issue_addr", b_addr, 9);
        tick; tick;
        chk("b_t4_re", b_re, 0); chk("b_t4_en", b_en, 1); chk("b_t4_cnt", b_cnt, 0);
        b_cd = 1; tick; b_cd = 0;
        chk("b_t4_ign_re", b_re, 0); chk("b_t4_ign_col", b_cj, 1); chk("b_t5_cnt", b_cnt, 1);
        tick;
        chk("b_t6_cnt", b_cnt, 2); chk("b_t6_en", b_en, 1);
        tick;
        chk("b_empty_en", b_en, 0);
        b_cd = 1; tick; b_cd = 0;
        chk("b_acc_re", b_re, 1); chk("b_acc_col", b_cj, 2); chk("b_acc_addr", b_addr, 1);
        chk("b_n_en", b_cnt_q.size(), 3);
        if (b_cnt_q.size() == 3) for (int q = 0; q < 3; q++) chk("b_en_cnt", b_cnt_q[q], q);

        // C: RD_LAT=2, reset in the k=1 issue cycle
        c_st = 1; tick; c_st = 0;
        tick;
        chk("c_k1_addr", c_addr, 9);
        c_rst = 1; tick; c_rst = 0;
        chk("c_rst_re", c_re, 0);   chk("c_rst_addr", c_addr, 0); chk("c_rst_en", c_en, 0);
        chk("c_rst_cnt", c_cnt, 0); chk("c_rst_busy", c_busy, 0); chk("c_rst_done", c_done, 0);
        chk("c_rst_row", c_ri, 1);  chk("c_rst_col", c_cj, 1);
        repeat (4) begin tick; chk("c_no_en", c_en, 0); end
        c_st = 1; tick; c_st = 0;
        chk("c_re0", c_addr, 0); chk("c_busy", c_busy, 1);
        tick; chk("c_re1", c_addr, 9);
        tick; chk("c_re2", c_addr, 1);

        // D: single-cell matrix
        d_st = 1; tick; d_st = 0;
        chk("d_diag", d_addr, 0);
        tick; chk("d_left", d_addr, 2);
        tick; chk("d_up", d_addr, 1);
        tick; chk("d_wait_re", d_re, 0); chk("d_cnt2", d_cnt, 2);
        tick; chk("d_empty", d_en, 0);
        d_cd = 1; tick; d_cd = 0;
        chk("d_done", d_done, 1); chk("d_done_busy", d_busy, 1);
        tick;
        chk("d_done_end", d_done, 0); chk("d_idle", d_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
